hidden_layer_mac: RTL and testbench
===================================

Name: hidden_layer_mac

Overview:
- Downstream consumer of the weight/bias loader: computes the first hidden layer h[j] = ReLU(sum_i x[i]*W[i][j] + b[j]) for all N_HID neurons.
- Uses one time-multiplexed signed multiplier.
- Reads weights and biases through synchronous read ports with 1-cycle latency, backed by the loader's storage.
- Streams each neuron result out with a valid strobe to the output-layer stage.

Parameters:
- N_IN, 7, number of input features
- N_HID, 128, number of hidden neurons
- DW, 9, signed fixed-point data width (Q5.4)
- FRAC, 4, fractional bits of every operand
- ACCW, 24, signed accumulator width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to run one inference; ignored while busy
- x_in  in  N_IN*DW  packed signed inputs, x[i] = x_in[i*DW +: DW]; sampled on accepted start
- w_addr  out  $clog2(N_IN*N_HID)  weight read address = i*N_HID + j
- w_data  in  DW  signed weight, valid the cycle after w_addr
- b_addr  out  $clog2(N_HID)  bias read address = j
- b_data  in  DW  signed bias, valid the cycle after b_addr
- busy  out  1  high from the cycle after accepted start until done
- h_valid  out  1  one-cycle strobe, h_idx/h_data valid
- h_idx  out  $clog2(N_HID)  neuron index j of h_data
- h_data  out  DW  activated neuron output, range 0..255
- done  out  1  one-cycle pulse after the last neuron

Behaviour:
- Reset: all outputs 0, FSM to IDLE, accumulator and counters cleared. Reset mid-run aborts immediately; no further h_valid is issued.
- States: IDLE, ADDR, MAC, ACT, FIN.
- IDLE:
  - start=1 latches x_in into internal registers and sets j=0 -> ADDR.
  - start=0 -> stay in IDLE.
- ADDR (1 cycle): drive b_addr=j and w_addr=0*N_HID+j; set i=1 -> MAC.
- MAC (N_IN cycles, k=1..N_IN):
  - k=1: acc = sext(b_data) <<< FRAC + w_data*x[0].
  - k>1: acc += w_data*x[k-1].
  - While k<N_IN, drive w_addr = k*N_HID + j in the same cycle.
  - After k=N_IN -> ACT.
- ACT (1 cycle):
  - r = acc >>> FRAC (arithmetic).
  - h_data = 0 if r<0; 255 if r>255; else r[DW-1:0].
  - h_idx=j, h_valid=1.
  - If j==N_HID-1 -> FIN, else j++ -> ADDR.
- FIN: done=1 and busy=0 on this cycle -> IDLE.
- Timing:
  - Per-neuron latency is N_IN+2 cycles (9 at defaults).
  - The first h_valid comes 9 cycles after the start edge.
  - Total run is N_HID*(N_IN+2)+1 = 1153 cycles.
- Arithmetic:
  - Products are full 2*DW signed, sign-extended to ACCW.
  - Bias is aligned to Q.8 by the <<< FRAC shift.
  - No accumulator overflow is possible at the defaults: |acc| < 2^19.
- Boundary behaviour:
  - start while busy is ignored, with no restart.
  - start in the same cycle as FIN is ignored; it must be re-asserted in IDLE.
  - x_in changes during a run have no effect.
  - h_valid and done are never high in the same cycle.
  - Addresses hold their last value outside ADDR/MAC.

Optional Feature:
- Macro: HIDDEN_MAC_ROUND_EN.
- Defined: in ACT, r = (acc + (1 <<< (FRAC-1))) >>> FRAC, i.e. round-half-up before ReLU and saturation.
- Undefined: pure arithmetic-shift truncation (floor).
- Latency is identical in both cases.

Test Plan:
- All x=16 (1.0), all W=16, all b=0, start -> 128 h_valid strobes, h_data=112 each, h_idx 0..127 in order; done exactly 1153 cycles after the start edge.
- As above with b[j]=32 (2.0) -> every h_data=144; the first h_valid occurs 9 cycles after start.
- All W=-16, b=0, x=16 -> every h_data=0 (ReLU clamp); W=255, x=255 -> every h_data=255 (saturation).
- x[0]=1, other x=0, W=8, b=0 -> h_data=0 without the macro, h_data=1 with HIDDEN_MAC_ROUND_EN.
- Sequencing checks:
  - start pulsed at neuron 40 -> ignored, output sequence unchanged.
  - rst_n dropped at neuron 60 -> outputs 0 immediately, no done.
  - A new start after release runs from j=0 correctly.
- Distinct per-address W/b pattern (W[i][j]=i+j, b[j]=j) -> h_data matches a golden model for all 128 neurons; w_addr/b_addr sequence is checked every cycle.

Source files
------------

// File: rtl/hidden_layer_mac.sv
// hidden_layer_mac: first hidden layer h[j] = ReLU(sum_i x[i]*W[i][j] + b[j]) on one shared multiplier.
// Define HIDDEN_MAC_ROUND_EN for round-half-up before activation; the default is floor truncation.
module hidden_layer_mac #(
  parameter int N_IN  = 7,
  parameter int N_HID = 128,
  parameter int DW    = 9,
  parameter int FRAC  = 4,
  parameter int ACCW  = 24,
  localparam int WAW  = $clog2(N_IN*N_HID),
  localparam int HW   = $clog2(N_HID)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_IN*DW-1:0] x_in,
  output logic [WAW-1:0]     w_addr,
  input  logic [DW-1:0]      w_data,
  output logic [HW-1:0]      b_addr,
  input  logic [DW-1:0]      b_data,
  output logic               busy,
  output logic               h_valid,
  output logic [HW-1:0]      h_idx,
  output logic [DW-1:0]      h_data,
  output logic               done
);

  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [KW-1:0]  K_LAST      = KW'(N_IN-1);
  localparam logic [KW-1:0]  K_STEP_LAST = KW'(N_IN-2);
  localparam logic [HW-1:0]  J_LAST      = HW'(N_HID-1);
  localparam logic [WAW-1:0] ROW_STEP    = WAW'(N_HID);
  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << (DW-1)) - 1);

  typedef enum logic [2:0] {IDLE, ADDR, MAC, ACT, FIN} state_t;

  state_t state, state_next;

  logic signed [DW-1:0]     x_reg [N_IN];
  logic [KW-1:0]            k_idx;
  logic [HW-1:0]            j;
  logic signed [ACCW-1:0]   acc;

  logic signed [DW-1:0]     w_s;
  logic signed [DW-1:0]     b_s;
  logic signed [DW-1:0]     x_sel;
  logic signed [2*DW-1:0]   prod;
  logic signed [ACCW-1:0]   prod_ext;
  logic signed [ACCW-1:0]   bias_ext;
  logic signed [ACCW-1:0]   acc_r;
  logic signed [ACCW-1:0]   r;
  logic [DW-1:0]            act;

  assign w_s      = w_data;
  assign b_s      = b_data;
  assign x_sel    = x_reg[k_idx];
  assign prod     = w_s * x_sel;
  assign prod_ext = ACCW'(prod);
  // Bias arrives in the operand format and must be lifted to the product's Q.(2*FRAC) scale.
  assign bias_ext = ACCW'(b_s) <<< FRAC;

  always_comb begin
`ifdef HIDDEN_MAC_ROUND_EN
    acc_r = acc + ACCW'(1 <<< (FRAC-1));
`else
    acc_r = acc;
`endif
    r = acc_r >>> FRAC;
    if (r[ACCW-1])
      act = '0;
    else if (r > SAT_MAX)
      act = SAT_MAX[DW-1:0];
    else
      act = r[DW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    h_valid    = 1'b0;
    h_idx      = '0;
    h_data     = '0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = ADDR;
      ADDR: begin
        busy       = 1'b1;
        state_next = MAC;
      end
      MAC: begin
        busy = 1'b1;
        if (k_idx == K_LAST) state_next = ACT;
      end
      ACT: begin
        busy       = 1'b1;
        h_valid    = 1'b1;
        h_idx      = j;
        h_data     = act;
        state_next = (j == J_LAST) ? FIN : ADDR;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses are registered on the edge entering the cycle that presents them, so the
  // one-cycle read latency lines each row's weight up with the MAC step that consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_IN; i++) x_reg[i] <= '0;
      j      <= '0;
      k_idx  <= '0;
      acc    <= '0;
      w_addr <= '0;
      b_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < N_IN; i++) x_reg[i] <= x_in[i*DW +: DW];
            j      <= '0;
            acc    <= '0;
            w_addr <= '0;
            b_addr <= '0;
          end
        end
        ADDR: begin
          k_idx  <= '0;
          w_addr <= w_addr + ROW_STEP;
        end
        MAC: begin
          acc <= (k_idx == '0) ? (bias_ext + prod_ext) : (acc + prod_ext);
          if (k_idx != K_LAST) k_idx <= k_idx + 1'b1;
          if (k_idx < K_STEP_LAST) w_addr <= w_addr + ROW_STEP;
        end
        ACT: begin
          if (j != J_LAST) begin
            j      <= j + 1'b1;
            w_addr <= WAW'(j + 1'b1);
            b_addr <= j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hidden_layer_mac.sv
// tb_hidden_layer_mac: table vectors, sequencing corner cases and random layers checked
// against a plain-arithmetic model of the hidden layer, with cycle-by-cycle address checks.
`timescale 1ns/1ps
module tb_hidden_layer_mac;

  localparam int N_IN       = 7;
  localparam int N_HID      = 128;
  localparam int DW         = 9;
  localparam int FRAC       = 4;
  localparam int WAW        = $clog2(N_IN*N_HID);
  localparam int HW         = $clog2(N_HID);
  localparam int NEURON_CYC = N_IN + 2;
  localparam int RUN_CYC    = N_HID*NEURON_CYC + 1;
`ifdef HIDDEN_MAC_ROUND_EN
  localparam int X0_EXP = 1;
`else
  localparam int X0_EXP = 0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [N_IN*DW-1:0] x_in;
  logic [WAW-1:0]     w_addr;
  logic [DW-1:0]      w_data;
  logic [HW-1:0]      b_addr;
  logic [DW-1:0]      b_data;
  logic               busy;
  logic               h_valid;
  logic [HW-1:0]      h_idx;
  logic [DW-1:0]      h_data;
  logic               done;

  int vectors     = 0;
  int miscompares = 0;

  int wmem [N_IN*N_HID];
  int bmem [N_HID];
  int xv   [N_IN];
  int h_exp[N_HID];

  typedef struct {
    int xval;
    int wval;
    int bval;
    bit x0_only;
    int exp;
  } vec_t;

  vec_t tbl[5];

  hidden_layer_mac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .x_in    (x_in),
    .w_addr  (w_addr),
    .w_data  (w_data),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .busy    (busy),
    .h_valid (h_valid),
    .h_idx   (h_idx),
    .h_data  (h_data),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Loader storage stand-in: synchronous read, data valid the cycle after the address.
  always @(posedge clk) begin
    w_data <= DW'(wmem[w_addr]);
    b_data <= DW'(bmem[b_addr]);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int activate(input int acc);
    real q;
    int  r;
    q = $itor(acc) / $itor(1 << FRAC);
`ifdef HIDDEN_MAC_ROUND_EN
    r = $rtoi($floor(q + 0.5));
`else
    r = $rtoi($floor(q));
`endif
    if (r < 0) return 0;
    if (r > 255) return 255;
    return r;
  endfunction

  function automatic void compute_model();
    int acc;
    for (int jn = 0; jn < N_HID; jn++) begin
      acc = bmem[jn] * (1 << FRAC);
      for (int i = 0; i < N_IN; i++) acc += xv[i] * wmem[i*N_HID + jn];
      h_exp[jn] = activate(acc);
    end
  endfunction

  function automatic int rand_signed(input int lo, input int hi);
    return int'($urandom_range(0, hi - lo)) + lo;
  endfunction

  task automatic check_output(input string what, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", what, actual, expected);
    end
  endtask

  // One inference; optionally pulse start mid-run (with new x_in), abort with reset at a
  // given neuron, or assert start during the FIN cycle. Negative neuron numbers disable.
  task automatic apply_stimulus(input int pulse_at, input int reset_at, input bit start_in_fin);
    int got;
    int jn, t, row, wa, ba;
    bit bz, hv, dn;
    got = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < N_IN; i++) x_in[i*DW +: DW] = DW'(xv[i]);
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= RUN_CYC + 3; c++) begin
      if (c == reset_at*NEURON_CYC + 3) begin
        rst_n = 1'b0;
        #1;
        check_output("abort outputs {busy,h_valid,done,h_idx,h_data}",
                     32'({busy, h_valid, done, h_idx, h_data}), 32'd0);
        check_output("abort addresses {w_addr,b_addr}", 32'({w_addr, b_addr}), 32'd0);
        repeat (3) begin
          @(negedge clk);
          check_output("abort quiet {busy,h_valid,done}", 32'({busy, h_valid, done}), 32'd0);
        end
        check_output("abort strobe count", 32'(got), 32'(reset_at));
        rst_n = 1'b1;
        return;
      end
      if (c < RUN_CYC) begin
        jn  = (c - 1) / NEURON_CYC;
        t   = (c - 1) % NEURON_CYC;
        row = (t == 0) ? 0 : ((t < N_IN) ? t : N_IN - 1);
        wa  = row*N_HID + jn;
        ba  = jn;
        bz  = 1'b1;
        hv  = (t == NEURON_CYC - 1);
        dn  = 1'b0;
      end else begin
        wa = (N_IN - 1)*N_HID + N_HID - 1;
        ba = N_HID - 1;
        bz = 1'b0;
        hv = 1'b0;
        dn = (c == RUN_CYC);
      end
      check_output($sformatf("cycle %0d {busy,h_valid,done,w_addr,b_addr}", c),
                   32'({busy, h_valid, done, w_addr, b_addr}),
                   32'({bz, hv, dn, WAW'(wa), HW'(ba)}));
      if (h_valid === 1'b1 && got < N_HID) begin
        check_output($sformatf("neuron %0d h_idx", got), 32'(h_idx), 32'(got));
        check_output($sformatf("neuron %0d h_data", got), 32'(h_data), 32'(h_exp[got]));
        got++;
      end
      start = (c == pulse_at*NEURON_CYC + 4) || (start_in_fin && c == RUN_CYC);
      if (c == pulse_at*NEURON_CYC + 4) x_in = {$urandom, $urandom};
      @(negedge clk);
    end
    start = 1'b0;
    check_output("strobe count", 32'(got), 32'(N_HID));
  endtask

  task automatic fill_random(input int lo, input int hi);
    for (int a = 0; a < N_IN*N_HID; a++) wmem[a] = rand_signed(lo, hi);
    for (int a = 0; a < N_HID; a++) bmem[a] = rand_signed(lo, hi);
    for (int i = 0; i < N_IN; i++) xv[i] = rand_signed(lo, hi);
    compute_model();
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    x_in  = '0;
    for (int a = 0; a < N_IN*N_HID; a++) wmem[a] = 0;
    for (int a = 0; a < N_HID; a++) bmem[a] = 0;
    repeat (2) @(negedge clk);
    check_output("reset {busy,h_valid,done,h_idx,h_data}",
                 32'({busy, h_valid, done, h_idx, h_data}), 32'd0);
    check_output("reset {w_addr,b_addr}", 32'({w_addr, b_addr}), 32'd0);
    rst_n = 1'b1;

    tbl[0] = '{16,  16,  0,  1'b0, 112};
    tbl[1] = '{16,  16,  32, 1'b0, 144};
    tbl[2] = '{16,  -16, 0,  1'b0, 0};
    tbl[3] = '{255, 255, 0,  1'b0, 255};
    tbl[4] = '{1,   8,   0,  1'b1, X0_EXP};

    for (int v = 0; v < 5; v++) begin
      $display("[TB] table vector %0d", v);
      for (int a = 0; a < N_IN*N_HID; a++) wmem[a] = tbl[v].wval;
      for (int a = 0; a < N_HID; a++) bmem[a] = tbl[v].bval;
      for (int i = 0; i < N_IN; i++) xv[i] = (tbl[v].x0_only && i != 0) ? 0 : tbl[v].xval;
      for (int a = 0; a < N_HID; a++) h_exp[a] = tbl[v].exp;
      apply_stimulus(-1, -1, 1'b0);
    end

    $display("[TB] per-address pattern, start pulsed at neuron 40 and during FIN");
    for (int i = 0; i < N_IN; i++)
      for (int jn = 0; jn < N_HID; jn++) wmem[i*N_HID + jn] = i + jn;
    for (int jn = 0; jn < N_HID; jn++) bmem[jn] = jn;
    for (int i = 0; i < N_IN; i++) xv[i] = rand_signed(-32, 32);
    compute_model();
    apply_stimulus(40, -1, 1'b1);

    $display("[TB] reset abort at neuron 60, then fresh run");
    fill_random(-24, 24);
    apply_stimulus(-1, 60, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check_output("idle after abort {busy,h_valid,done}", 32'({busy, h_valid, done}), 32'd0);
    end
    apply_stimulus(-1, -1, 1'b0);

    $display("[TB] random full-range layer");
    fill_random(-256, 255);
    apply_stimulus(-1, -1, 1'b0);

    $display("[TB] random small-range layer");
    fill_random(-20, 20);
    apply_stimulus(-1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
